id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Pipeline sequencing controller for the decode stage. It detects load-use hazards between the instruction in ID and a load in EX, and sequences multi-cycle bubbles and front-end flushes after EX redirects. It freezes the pipe while data memory is busy. It drives the IF/ID and ID/EX register enables, flushes and bubbles around the ID datapath (immediate generator, register file read) and exposes two stall/flush performance counters.

## Interface
Parameters:
- FETCH_LAT, 1: instruction-memory latency in cycles; number of stale fetches to discard after a redirect (≥1).
- LOAD_LAT, 1: bubbles required between a load in EX and a dependent instruction in ID (≥1).

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid_id  in  1  IF/ID holds a valid instruction.
- i_rs1_id, i_rs2_id  in  5 each  source register addresses of the ID instruction.
- i_rs1_use_id, i_rs2_use_id  in  1 each  corresponding source is actually read.
- i_valid_ex  in  1  ID/EX holds a valid instruction.
- i_rd_ex  in  5  destination register of the EX instruction.
- i_memrd_ex  in  1  EX instruction is a load.
- i_redirect_ex  in  1  EX resolved a taken branch/jump; PC must load the target.
- i_dmem_busy  in  1  MEM stage waiting on data memory.
- o_pc_en  out  1  PC update enable.
- o_ifid_en  out  1  IF/ID register enable.
- o_ifid_flush  out  1  IF/ID valid cleared on the next edge.
- o_idex_en  out  1  ID/EX register enable.
- o_idex_bubble  out  1  ID/EX loaded with a NOP (valid=0).
- o_state  out  2  current FSM state, for debug.
- o_stall_cnt  out  32  cycles spent in load-use stall.
- o_flush_cnt  out  32  cycles with o_ifid_flush asserted (excluding reset).

## Operation
- The FSM states are RUN=0, LU_STALL=1 and REDIR=2. A down-counter cnt is sized $clog2(max(FETCH_LAT,LOAD_LAT))+1.
- lu_hazard is true when all of the following hold: i_valid_id, i_valid_ex, i_memrd_ex, i_rd_ex≠0, and either (i_rs1_use_id and i_rs1_id==i_rd_ex) or (i_rs2_use_id and i_rs2_id==i_rd_ex).
- Outputs are Mealy (combinational from state, cnt and inputs). Priority, highest first:
  1. i_rst: o_pc_en=0, o_ifid_en=0, o_ifid_flush=1, o_idex_en=1, o_idex_bubble=1.
  2. i_dmem_busy: all enables 0, no flush, no bubble. State, cnt and counters hold. A redirect or hazard asserted in the same cycle is ignored and must be re-presented by upstream, which holds its registers.
  3. i_redirect_ex (any state): o_pc_en=1, o_ifid_en=1, o_ifid_flush=1, o_idex_en=1, o_idex_bubble=1.
     - If FETCH_LAT>1, go to REDIR with cnt=FETCH_LAT-1; otherwise go to RUN.
     - This aborts any LU_STALL in progress.
  4. REDIR: same outputs as item 3. cnt decrements each cycle; when cnt==1, return to RUN.
  5. RUN with lu_hazard: o_pc_en=0, o_ifid_en=0, o_idex_en=1, o_idex_bubble=1.
     - If LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-1.
  6. LU_STALL: same outputs as item 5, regardless of lu_hazard. cnt decrements; when cnt==1, return to RUN.
  7. RUN otherwise: all enables 1, no flush, no bubble.
- o_stall_cnt increments in each cycle where item 5 or 6 applies.
- o_flush_cnt increments in each cycle where item 3 or 4 applies.
- Both counters wrap 0xFFFF_FFFF→0 and clear on i_rst.

## Timing
- Response to a hazard or redirect is zero-latency (same cycle as the inputs). Sequencing in the following cycles comes from registered state.
- Reset: after an i_rst edge, state=RUN, cnt=0, both counters 0, o_state=0. While i_rst is high, outputs follow item 1.
- Load-use costs exactly LOAD_LAT bubble cycles.
- A redirect costs exactly FETCH_LAT flush cycles. A new redirect inside REDIR restarts the count.
- Reset mid-operation aborts any state immediately.
- i_dmem_busy during LU_STALL or REDIR stretches the sequence by the busy cycles without changing cnt.

## Structure
- Package id_ctrl_pkg holds:
  - the state enum (RUN, LU_STALL, REDIR, 2-bit encoding);
  - localparam defaults for FETCH_LAT and LOAD_LAT;
  - a packed struct for the five pipe-control outputs.
- Sub-module id_perf_cnt: a 32-bit wrapping counter with synchronous clear and increment enable. It is instantiated twice.

## Test plan
- Reset: hold i_rst 2 cycles with i_redirect_ex=1 -> outputs per item 1; after release, o_state=0 and both counters 0.
- Load-use, LOAD_LAT=2: i_rd_ex=5, i_memrd_ex=1, i_rs2_id=5 with use=1 -> o_pc_en=0 and o_idex_bubble=1 for exactly 2 cycles; o_stall_cnt=2. Repeat with i_rd_ex=0 -> no stall.
- Redirect, FETCH_LAT=3: pulse i_redirect_ex 1 cycle -> o_ifid_flush=1 for 3 cycles with o_pc_en=1; o_flush_cnt=3. A second pulse in cycle 2 of the flush extends the flush to a total of 4 cycles.
- Simultaneous: lu_hazard and i_redirect_ex in the same cycle -> redirect outputs, state REDIR, o_stall_cnt unchanged.
- Freeze: i_dmem_busy=1 for 4 cycles in the middle of LU_STALL (LOAD_LAT=3) -> all enables 0 during busy; the stall resumes after busy with the remaining count; o_stall_cnt=3.
- Wrap: force o_stall_cnt to 0xFFFF_FFFF, then trigger one stall cycle -> o_stall_cnt=0.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared types for the decode-stage sequencing controller: FSM state encoding,
// latency defaults and the pipe-control bundle driven onto the IF/ID and ID/EX registers.
package id_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIR    = 2'd2
  } state_t;

  localparam int FETCH_LAT_DEF = 1;
  localparam int LOAD_LAT_DEF  = 1;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/id_perf_cnt.sv
// 32-bit wrapping event counter, synchronous clear has priority over increment.
// One-cycle update latency; no backpressure.
module id_perf_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer: load-use bubbles, post-redirect flushes, dmem freeze; controls are
// combinational from inputs (zero latency), multi-cycle sequencing runs from registered state.
module id_hazard_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int FETCH_LAT = FETCH_LAT_DEF,
  parameter int LOAD_LAT  = LOAD_LAT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_id,
  input  logic [4:0]  i_rs1_id,
  input  logic [4:0]  i_rs2_id,
  input  logic        i_rs1_use_id,
  input  logic        i_rs2_use_id,
  input  logic        i_valid_ex,
  input  logic [4:0]  i_rd_ex,
  input  logic        i_memrd_ex,
  input  logic        i_redirect_ex,
  input  logic        i_dmem_busy,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_en,
  output logic        o_idex_bubble,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam int MAX_LAT = (FETCH_LAT > LOAD_LAT) ? FETCH_LAT : LOAD_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pipe_ctrl_t    ctrl;
  logic          lu_hazard;
  logic          stall_inc;
  logic          flush_inc;

  assign lu_hazard = i_valid_id && i_valid_ex && i_memrd_ex && (i_rd_ex != 5'd0) &&
                     ((i_rs1_use_id && (i_rs1_id == i_rd_ex)) ||
                      (i_rs2_use_id && (i_rs2_id == i_rd_ex)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A busy data memory freezes everything, so an upstream redirect/hazard seen then is dropped.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (i_rst) begin
      ctrl = CTRL_RESET;
    end else if (i_dmem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (i_redirect_ex || state_q == REDIR) begin
      ctrl      = CTRL_FLUSH;
      flush_inc = 1'b1;
      if (i_redirect_ex) begin
        if (FETCH_LAT > 1) begin
          state_d = REDIR;
          cnt_d   = CW'(FETCH_LAT - 1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
    end else if (state_q == LU_STALL || lu_hazard) begin
      ctrl      = CTRL_STALL;
      stall_inc = 1'b1;
      if (state_q == LU_STALL) begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end else if (LOAD_LAT > 1) begin
        state_d = LU_STALL;
        cnt_d   = CW'(LOAD_LAT - 1);
      end
    end
  end

  assign o_pc_en       = ctrl.pc_en;
  assign o_ifid_en     = ctrl.ifid_en;
  assign o_ifid_flush  = ctrl.ifid_flush;
  assign o_idex_en     = ctrl.idex_en;
  assign o_idex_bubble = ctrl.idex_bubble;
  assign o_state       = state_q;

  id_perf_cnt u_stall_cnt (
    .clk   (i_clk),
    .clr   (i_rst),
    .inc   (stall_inc),
    .count (o_stall_cnt)
  );

  id_perf_cnt u_flush_cnt (
    .clk   (i_clk),
    .clr   (i_rst),
    .inc   (flush_inc),
    .count (o_flush_cnt)
  );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench: dut_a (FETCH_LAT=3, LOAD_LAT=2) and dut_b (FETCH_LAT=1, LOAD_LAT=3)
// share stimulus; control vectors are {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble}.
module tb_id_hazard_ctrl;

  localparam logic [4:0] V_RUN    = 5'b11010;
  localparam logic [4:0] V_STALL  = 5'b00011;
  localparam logic [4:0] V_FLUSH  = 5'b11111;
  localparam logic [4:0] V_RESET  = 5'b00111;
  localparam logic [4:0] V_FREEZE = 5'b00000;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_id, rs1_use, rs2_use, valid_ex, memrd, redirect, busy;
  logic [4:0] rs1, rs2, rd_ex;

  logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble;
  logic [1:0]  a_state;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble;
  logic [1:0]  b_state;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  wire [4:0] a_ctrl = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble};
  wire [4:0] b_ctrl = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.FETCH_LAT(3), .LOAD_LAT(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid_id(valid_id), .i_rs1_id(rs1), .i_rs2_id(rs2),
    .i_rs1_use_id(rs1_use), .i_rs2_use_id(rs2_use), .i_valid_ex(valid_ex), .i_rd_ex(rd_ex),
    .i_memrd_ex(memrd), .i_redirect_ex(redirect), .i_dmem_busy(busy),
    .o_pc_en(a_pc_en), .o_ifid_en(a_ifid_en), .o_ifid_flush(a_ifid_flush),
    .o_idex_en(a_idex_en), .o_idex_bubble(a_idex_bubble), .o_state(a_state),
    .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
  );

  id_hazard_ctrl #(.FETCH_LAT(1), .LOAD_LAT(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid_id(valid_id), .i_rs1_id(rs1), .i_rs2_id(rs2),
    .i_rs1_use_id(rs1_use), .i_rs2_use_id(rs2_use), .i_valid_ex(valid_ex), .i_rd_ex(rd_ex),
    .i_memrd_ex(memrd), .i_redirect_ex(redirect), .i_dmem_busy(busy),
    .o_pc_en(b_pc_en), .o_ifid_en(b_ifid_en), .o_ifid_flush(b_ifid_flush),
    .o_idex_en(b_idex_en), .o_idex_bubble(b_idex_bubble), .o_state(b_state),
    .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle, then let new inputs settle before sampling
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_hazard(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                            input logic u2, input logic [4:0] rd);
    valid_id = 1'b1; valid_ex = 1'b1; memrd = 1'b1;
    rs1 = r1; rs1_use = u1; rs2 = r2; rs2_use = u2; rd_ex = rd;
  endtask

  task automatic clear_hazard();
    valid_ex = 1'b0; memrd = 1'b0; rd_ex = 5'd0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b1; busy = 1'b0;
    valid_id = 1'b0; valid_ex = 1'b0; memrd = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rs1_use = 1'b0; rs2_use = 1'b0; rd_ex = 5'd0;

    // reset with a redirect pending
    tick(); #1;
    check("rst_ctrl_c0", a_ctrl, V_RESET);
    tick(); #1;
    check("rst_ctrl_c1", a_ctrl, V_RESET);
    check("rst_ctrl_b", b_ctrl, V_RESET);
    tick(); rst = 1'b0; redirect = 1'b0; #1;
    check("rst_state", a_state, 2'd0);
    check("rst_stall_cnt", a_stall_cnt, 32'd0);
    check("rst_flush_cnt", a_flush_cnt, 32'd0);
    check("rst_run_ctrl", a_ctrl, V_RUN);

    // load-use through rs2: a bubbles 2 cycles, b bubbles 3
    set_hazard(5'd1, 1'b1, 5'd5, 1'b1, 5'd5); #1;
    check("lu_c0_a", a_ctrl, V_STALL);
    check("lu_c0_b", b_ctrl, V_STALL);
    tick(); clear_hazard(); #1;
    check("lu_c1_a", a_ctrl, V_STALL);
    check("lu_c1_state", a_state, 2'd1);
    tick(); #1;
    check("lu_c2_a_run", a_ctrl, V_RUN);
    check("lu_a_stall_cnt", a_stall_cnt, 32'd2);
    check("lu_c2_b", b_ctrl, V_STALL);
    tick(); #1;
    check("lu_c3_b_run", b_ctrl, V_RUN);
    check("lu_b_stall_cnt", b_stall_cnt, 32'd3);

    // no hazard: rd=0, then rs1 match with use cleared
    set_hazard(5'd0, 1'b1, 5'd0, 1'b1, 5'd0); #1;
    check("lu_rd0_ctrl", a_ctrl, V_RUN);
    tick(); set_hazard(5'd7, 1'b0, 5'd3, 1'b1, 5'd7); #1;
    check("lu_nouse_ctrl", a_ctrl, V_RUN);
    tick(); clear_hazard(); #1;
    check("lu_none_cnt", a_stall_cnt, 32'd2);

    // single redirect: a flushes 3 cycles, b flushes 1
    redirect = 1'b1; #1;
    check("rd_c0_a", a_ctrl, V_FLUSH);
    check("rd_c0_b", b_ctrl, V_FLUSH);
    tick(); redirect = 1'b0; #1;
    check("rd_c1_a", a_ctrl, V_FLUSH);
    check("rd_c1_state", a_state, 2'd2);
    check("rd_c1_b_run", b_ctrl, V_RUN);
    tick(); #1;
    check("rd_c2_a", a_ctrl, V_FLUSH);
    tick(); #1;
    check("rd_c3_a_run", a_ctrl, V_RUN);
    check("rd_a_flush_cnt", a_flush_cnt, 32'd3);
    check("rd_b_flush_cnt", b_flush_cnt, 32'd1);

    // second redirect in flush cycle 2 restarts: 4 flush cycles total
    redirect = 1'b1; #1;
    check("rd2_c0", a_ctrl, V_FLUSH);
    tick(); #1;
    check("rd2_c1", a_ctrl, V_FLUSH);
    tick(); redirect = 1'b0; #1;
    check("rd2_c2", a_ctrl, V_FLUSH);
    tick(); #1;
    check("rd2_c3", a_ctrl, V_FLUSH);
    tick(); #1;
    check("rd2_c4_run", a_ctrl, V_RUN);
    check("rd2_flush_cnt", a_flush_cnt, 32'd7);

    // hazard and redirect together: redirect wins
    set_hazard(5'd9, 1'b1, 5'd0, 1'b0, 5'd9); redirect = 1'b1; #1;
    check("sim_ctrl", a_ctrl, V_FLUSH);
    tick(); clear_hazard(); redirect = 1'b0; #1;
    check("sim_state", a_state, 2'd2);
    check("sim_stall_a", a_stall_cnt, 32'd2);
    check("sim_stall_b", b_stall_cnt, 32'd3);
    tick(); tick(); #1;
    check("sim_run", a_ctrl, V_RUN);
    check("sim_flush_cnt", a_flush_cnt, 32'd10);

    // dmem busy for 4 cycles inside b's 3-cycle load-use stall
    set_hazard(5'd4, 1'b1, 5'd0, 1'b0, 5'd4); #1;
    check("frz_c0_b", b_ctrl, V_STALL);
    tick(); clear_hazard(); #1;
    check("frz_c1_b", b_ctrl, V_STALL);
    tick(); busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("frz_busy%0d_b", i), b_ctrl, V_FREEZE);
      check($sformatf("frz_busy%0d_a", i), a_ctrl, V_FREEZE);
      check($sformatf("frz_busy%0d_st", i), b_state, 2'd1);
      tick();
    end
    busy = 1'b0; #1;
    check("frz_resume_b", b_ctrl, V_STALL);
    tick(); #1;
    check("frz_done_b", b_ctrl, V_RUN);
    check("frz_done_state", b_state, 2'd0);
    check("frz_b_stall_cnt", b_stall_cnt, 32'd6);
    check("frz_a_stall_cnt", a_stall_cnt, 32'd4);

    // stall counter wraps
    force dut_a.u_stall_cnt.count = 32'hFFFF_FFFF;
    tick();
    release dut_a.u_stall_cnt.count;
    #1;
    check("wrap_preset", a_stall_cnt, 32'hFFFF_FFFF);
    set_hazard(5'd6, 1'b1, 5'd0, 1'b0, 5'd6);
    tick(); clear_hazard(); #1;
    check("wrap_zero", a_stall_cnt, 32'd0);
    tick(); #1;
    check("wrap_one", a_stall_cnt, 32'd1);
    tick(); tick();

    // reset in the middle of a redirect flush
    redirect = 1'b1;
    tick(); redirect = 1'b0; rst = 1'b1; #1;
    check("mid_rst_ctrl", a_ctrl, V_RESET);
    tick(); rst = 1'b0; #1;
    check("mid_rst_state", a_state, 2'd0);
    check("mid_rst_ctrl_run", a_ctrl, V_RUN);
    check("mid_rst_flush", a_flush_cnt, 32'd0);
    check("mid_rst_stall_b", b_stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
